// File: rtl/ams_spi_pkg.sv
// Shared definitions for both ends of the SPI-to-Avalon link: frame preambles,
// the frame CRC and the slave state encoding.
package ams_spi_pkg;

  localparam logic [31:0] WRITE_WORD = 32'hAAAA_AAAA;
  localparam logic [31:0] READ_WORD  = 32'hBBBB_BBBB;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PRE,
    S_ADDR,
    S_WDATA,
    S_WCRC,
    S_BUS,
    S_ACK,
    S_RDATA,
    S_RCRC,
    S_DONE
  } slave_state_e;

  function automatic logic [31:0] crc(input logic [31:0] a,
                                      input logic [31:0] b,
                                      input logic [31:0] c);
    return a ^ b ^ c;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous input, with single-cycle rise and
// fall pulses derived from the synchronized level.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // Resetting to the line's idle level keeps the edge detector quiet after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      sync <= RESET_VAL;
      prev <= RESET_VAL;
    end else begin
      // NOTE: non-blocking assignments give a true three-stage chain; blocking would collapse it to one flop.
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;

endmodule

// File: rtl/spi_amm_slave.sv
// SPI frame decoder that turns each write/read frame into one Avalon-MM master
// transaction and returns ack, read data and CRC on MISO.
module spi_amm_slave
  import ams_spi_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int BUS_TIMEOUT = 32
) (
  input  logic                  main_clk,
  input  logic                  main_reset,
  input  logic                  SCLK,
  input  logic                  MOSI,
  input  logic                  nSS,
  output logic                  MISO,
  output logic [ADDR_WIDTH-1:0] amm_address,
  output logic [31:0]           amm_writedata,
  output logic                  amm_write,
  output logic                  amm_read,
  input  logic [31:0]           amm_readdata,
  input  logic                  amm_readdatavalid,
  input  logic                  amm_waitrequest,
  output logic [1:0]            err_pulse
);

  localparam int TW = $clog2(BUS_TIMEOUT + 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic nss_s, nss_rise, nss_fall;
  logic mosi_meta, mosi_s;

  spi_sync_edge #(.RESET_VAL(1'b1)) u_sclk_sync (
    .clk   (main_clk),
    .rst   (main_reset),
    .din   (SCLK),
    .level (sclk_s),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_nss_sync (
    .clk   (main_clk),
    .rst   (main_reset),
    .din   (nSS),
    .level (nss_s),
    .rise  (nss_rise),
    .fall  (nss_fall)
  );

  // MOSI shares the SCLK sync latency, so mosi_s is aligned with sclk_rise.
  always_ff @(posedge main_clk or posedge main_reset) begin
    if (main_reset) begin
      mosi_meta <= 1'b0;
      mosi_s    <= 1'b0;
    end else begin
      mosi_meta <= MOSI;
      mosi_s    <= mosi_meta;
    end
  end

  logic unused_edges;
  assign unused_edges = ^{sclk_s, sclk_fall, nss_rise, nss_fall};

  slave_state_e   state;
  logic [31:0]    shreg;
  logic [31:0]    addr_q;
  logic [31:0]    rdata_q;
  logic [4:0]     bit_cnt;
  logic [TW-1:0]  tmo_cnt;
  logic           is_write;
  logic           bus_abort;

  logic [31:0] rx_word;
  logic        last_bit;
  logic        abortable;

  assign rx_word     = {shreg[30:0], mosi_s};
  assign last_bit    = (bit_cnt == 5'd31);
  assign amm_address = addr_q[ADDR_WIDTH-1:0];
  assign abortable   = state inside {S_PRE, S_ADDR, S_WDATA, S_WCRC, S_ACK, S_RDATA, S_RCRC};

  always_ff @(posedge main_clk or posedge main_reset) begin
    if (main_reset) begin
      state         <= S_IDLE;
      MISO          <= 1'b1;
      amm_write     <= 1'b0;
      amm_read      <= 1'b0;
      amm_writedata <= '0;
      err_pulse     <= '0;
      addr_q        <= '0;
      shreg         <= '0;
      rdata_q       <= '0;
      bit_cnt       <= '0;
      tmo_cnt       <= '0;
      is_write      <= 1'b0;
      bus_abort     <= 1'b0;
    end else begin
      // NOTE: err_pulse defaults low every cycle, so any branch that sets it yields a one-cycle pulse.
      err_pulse <= '0;
      if (nss_s && abortable) begin
        state <= S_IDLE;
        MISO  <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            MISO <= 1'b1;
            if (!nss_s) begin
              state   <= S_PRE;
              bit_cnt <= '0;
            end
          end

          S_PRE, S_ADDR, S_WDATA, S_WCRC: begin
            if (sclk_rise) begin
              shreg   <= rx_word;
              bit_cnt <= bit_cnt + 5'd1;
              if (last_bit) begin
                if (state == S_PRE) begin
                  if (rx_word == WRITE_WORD || rx_word == READ_WORD) begin
                    is_write <= (rx_word == WRITE_WORD);
                    state    <= S_ADDR;
                  end else begin
                    err_pulse[0] <= 1'b1;
                    state        <= S_DONE;
                  end
                end else if (state == S_ADDR) begin
                  addr_q <= rx_word;
                  if (is_write) begin
                    state <= S_WDATA;
                  end else begin
                    amm_read  <= 1'b1;
                    tmo_cnt   <= '0;
                    bus_abort <= 1'b0;
                    state     <= S_BUS;
                  end
                end else if (state == S_WDATA) begin
                  amm_writedata <= rx_word;
                  state         <= S_WCRC;
                end else if (rx_word == crc(WRITE_WORD, addr_q, amm_writedata)) begin
                  amm_write <= 1'b1;
                  tmo_cnt   <= '0;
                  bus_abort <= 1'b0;
                  state     <= S_BUS;
                end else begin
                  err_pulse[0] <= 1'b1;
                  state        <= S_DONE;
                end
              end
            end
          end

          // An issued Avalon transfer cannot be cancelled; an nSS abort only discards its result.
          S_BUS: begin
            tmo_cnt <= tmo_cnt + TW'(1);
            if (nss_s) bus_abort <= 1'b1;
            if ((amm_write || amm_read) && !amm_waitrequest) begin
              amm_write <= 1'b0;
              amm_read  <= 1'b0;
              if (amm_write) state <= (bus_abort || nss_s) ? S_IDLE : S_ACK;
            end else if (!amm_write && !amm_read && amm_readdatavalid) begin
              rdata_q <= amm_readdata;
              state   <= (bus_abort || nss_s) ? S_IDLE : S_ACK;
            end else if (tmo_cnt == TW'(BUS_TIMEOUT - 1)) begin
              amm_write    <= 1'b0;
              amm_read     <= 1'b0;
              err_pulse[1] <= 1'b1;
              state        <= S_DONE;
            end
          end

          S_ACK: begin
            if (sclk_rise) begin
              MISO <= 1'b0;
              if (is_write) begin
                state <= S_DONE;
              end else begin
                shreg   <= rdata_q;
                bit_cnt <= '0;
                state   <= S_RDATA;
              end
            end
          end

          S_RDATA, S_RCRC: begin
            if (sclk_rise) begin
              MISO    <= shreg[31];
              shreg   <= {shreg[30:0], 1'b0};
              bit_cnt <= bit_cnt + 5'd1;
              if (last_bit) begin
                if (state == S_RDATA) begin
                  shreg <= crc(READ_WORD, addr_q, rdata_q);
                  state <= S_RCRC;
                end else begin
                  state <= S_DONE;
                end
              end
            end
          end

          // The last driven bit is held until the next rise so the master can sample it.
          S_DONE: begin
            if (nss_s) begin
              MISO  <= 1'b1;
              state <= S_IDLE;
            end else if (sclk_rise) begin
              MISO <= 1'b1;
            end
          end

          default: begin
            MISO  <= 1'b1;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
